glb_xbus_issuer: RTL and testbench



---
 rtl/xbus_pkg.sv | 29 ++
 rtl/glb_xbus_issuer_if.sv | 55 +++++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/glb_xbus_issuer.sv | 148 ++++++++++++++
 tb/tb_glb_xbus_issuer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_pkg.sv
// Shared types for the GLB-to-Y-bus issuer.
// XBUS_PSUM_EN adds the psum field to the FIFO entry.
package xbus_pkg;

    localparam int XBUS_DW         = 16;
    localparam int XBUS_NUM_ROW    = 4;
    localparam int XBUS_NUM_COL    = 4;
    localparam int XBUS_FIFO_DEPTH = 4;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        STREAM,
        FIN
    } state_t;

    typedef struct packed {
        logic [XBUS_DW-1:0]   ifmap;
        logic [XBUS_DW-1:0]   fltr;
`ifdef XBUS_PSUM_EN
        logic [2*XBUS_DW-1:0] psum;
`endif
    } fifo_entry_t;

endpackage

// File: rtl/glb_xbus_issuer_if.sv
// Control, GLB-side and Y-bus-side signals of the issuer.
// master is the issuer's view, slave the environment's view.
interface glb_xbus_issuer_if
    import xbus_pkg::*;
#(
    parameter int NUM_ROW = XBUS_NUM_ROW,
    parameter int NUM_COL = XBUS_NUM_COL
);
    localparam int RW = $clog2(NUM_ROW + 1);
    localparam int CW = $clog2(NUM_COL + 1);
    localparam int YW = tag_w(NUM_ROW);
    localparam int XW = tag_w(NUM_COL);

    logic                   start;
    logic [RW-1:0]          cfg_rows;
    logic [CW-1:0]          cfg_cols;
    logic                   busy;
    logic                   done;

    logic                   glb_valid;
    logic                   glb_ready;
    logic [XBUS_DW-1:0]     glb_ifmap;
    logic [XBUS_DW-1:0]     glb_fltr;
    logic [2*XBUS_DW-1:0]   glb_psum;

    logic [YW-1:0]          bus_y_tag;
    logic [XW-1:0]          bus_x_tag;
    logic                   bus_flush;
    logic                   bus_valid;
    logic                   bus_ready;
    logic [XBUS_DW-1:0]     bus_ifmap;
    logic [XBUS_DW-1:0]     bus_fltr;
    logic [2*XBUS_DW-1:0]   bus_psum;

    modport master (
        input  start, cfg_rows, cfg_cols,
        output busy, done,
        input  glb_valid, glb_ifmap, glb_fltr, glb_psum,
        output glb_ready,
        output bus_y_tag, bus_x_tag, bus_flush, bus_valid,
        output bus_ifmap, bus_fltr, bus_psum,
        input  bus_ready
    );

    modport slave (
        output start, cfg_rows, cfg_cols,
        input  busy, done,
        output glb_valid, glb_ifmap, glb_fltr, glb_psum,
        input  glb_ready,
        input  bus_y_tag, bus_x_tag, bus_flush, bus_valid,
        input  bus_ifmap, bus_fltr, bus_psum,
        output bus_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head entry is read straight from the storage flops.
// DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/glb_xbus_issuer.sv
// Schedules GLB words onto the Y-bus row by row, with a tag flush per row.
// Define XBUS_PSUM_EN to carry psum through the FIFO; otherwise bus_psum is 0.
module glb_xbus_issuer
    import xbus_pkg::*;
#(
    parameter int NUM_ROW    = XBUS_NUM_ROW,
    parameter int NUM_COL    = XBUS_NUM_COL,
    parameter int FIFO_DEPTH = XBUS_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    glb_xbus_issuer_if.master xif
);
    localparam int RW = $clog2(NUM_ROW + 1);
    localparam int CW = $clog2(NUM_COL + 1);
    localparam int YW = tag_w(NUM_ROW);
    localparam int XW = tag_w(NUM_COL);
    localparam int AW = $clog2(NUM_ROW * NUM_COL + 1);
    localparam int EW = $bits(fifo_entry_t);

    state_t        state_q, state_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [RW-1:0] y_cnt_q, y_cnt_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [AW-1:0] acc_cnt_q, acc_cnt_d;
    logic [AW-1:0] total;

    logic        busy, glb_ready, bus_valid;
    logic        push, pop, full, empty;
    logic        last_col, last_row;
    fifo_entry_t wr_entry, rd_entry;

    assign total     = AW'(rows_q) * AW'(cols_q);
    assign busy      = (state_q == TAG) || (state_q == STREAM);
    // Stop taking GLB words once the whole pass has been fetched.
    assign glb_ready = busy && !full && (acc_cnt_q < total);
    assign push      = xif.glb_valid && glb_ready;
    assign bus_valid = (state_q == STREAM) && !empty;
    assign pop       = bus_valid && xif.bus_ready;
    assign last_col  = (x_cnt_q == cols_q - CW'(1));
    assign last_row  = (y_cnt_q == rows_q - RW'(1));

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        y_cnt_d   = y_cnt_q;
        x_cnt_d   = x_cnt_q;
        acc_cnt_d = acc_cnt_q + AW'(push);
        unique case (state_q)
            IDLE: begin
                if (xif.start) begin
                    rows_d    = xif.cfg_rows;
                    cols_d    = xif.cfg_cols;
                    y_cnt_d   = '0;
                    x_cnt_d   = '0;
                    acc_cnt_d = '0;
                    if ((xif.cfg_rows != '0) && (xif.cfg_cols != '0)) begin
                        state_d = TAG;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            TAG: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (pop) begin
                    if (last_col) begin
                        x_cnt_d = '0;
                        y_cnt_d = y_cnt_q + RW'(1);
                        state_d = last_row ? FIN : TAG;
                    end else begin
                        x_cnt_d = x_cnt_q + CW'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            y_cnt_q   <= '0;
            x_cnt_q   <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            y_cnt_q   <= y_cnt_d;
            x_cnt_q   <= x_cnt_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.ifmap = xif.glb_ifmap;
        wr_entry.fltr  = xif.glb_fltr;
`ifdef XBUS_PSUM_EN
        wr_entry.psum  = xif.glb_psum;
`endif
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    assign xif.busy      = busy;
    assign xif.done      = (state_q == FIN);
    assign xif.glb_ready = glb_ready;
    assign xif.bus_flush = (state_q == TAG);
    assign xif.bus_valid = bus_valid;
    assign xif.bus_y_tag = y_cnt_q[YW-1:0];
    assign xif.bus_x_tag = x_cnt_q[XW-1:0];
    assign xif.bus_ifmap = rd_entry.ifmap;
    assign xif.bus_fltr  = rd_entry.fltr;

`ifdef XBUS_PSUM_EN
    assign xif.bus_psum = rd_entry.psum;
`else
    logic unused_psum;
    assign unused_psum  = ^xif.glb_psum;
    assign xif.bus_psum = '0;
`endif

endmodule

// File: tb/tb_glb_xbus_issuer.sv
// Randomised bench for glb_xbus_issuer against a queue-based transaction model.
// The model derives flush/beat/done timing from word and beat counts only.
module tb_glb_xbus_issuer;
    import xbus_pkg::*;

    localparam int DEPTH = XBUS_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    glb_xbus_issuer_if xif ();

    glb_xbus_issuer dut (
        .clk (clk),
        .rst (rst),
        .xif (xif)
    );

    typedef struct {
        logic [15:0] ifmap;
        logic [15:0] fltr;
        logic [31:0] psum;
    } word_t;

    int    n_chk = 0;
    int    n_err = 0;
    word_t m_q[$];
    bit    m_busy, m_done, m_flush;
    int    m_cols, m_total, m_pushed, m_beats;
    int    cyc_no = 0;
    int    done_seen_at;
    logic [15:0] seed;
    bit    psum_dead;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc_no);
        end
    endtask

    function automatic word_t gen_word(input int idx);
        word_t w;
        w.ifmap = 16'(seed + 16'(idx) + 16'd1);
        w.fltr  = 16'((idx + 1) * 40503) ^ ~seed;
        w.psum  = psum_dead ? 32'hDEADBEEF : ({w.fltr, w.ifmap} ^ 32'h5A5A_0000);
        return w;
    endfunction

    function automatic logic [31:0] exp_psum(input word_t w);
`ifdef XBUS_PSUM_EN
        return w.psum;
`else
        return (w.psum & 32'h0);
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy   = 0;
        m_done   = 0;
        m_flush  = 0;
        m_cols   = 1;
        m_total  = 0;
        m_pushed = 0;
        m_beats  = 0;
    endtask

    task automatic check_reset_outs();
        chk("rst_busy",      xif.busy,      0);
        chk("rst_done",      xif.done,      0);
        chk("rst_glb_ready", xif.glb_ready, 0);
        chk("rst_flush",     xif.bus_flush, 0);
        chk("rst_valid",     xif.bus_valid, 0);
        chk("rst_y_tag",     xif.bus_y_tag, 0);
        chk("rst_x_tag",     xif.bus_x_tag, 0);
        chk("rst_ifmap",     xif.bus_ifmap, 0);
        chk("rst_fltr",      xif.bus_fltr,  0);
        chk("rst_psum",      xif.bus_psum,  0);
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cyc(input bit st, input bit v, input bit r, input bit rs);
        word_t w;
        bit    exp_valid, exp_grdy, nb, nd, nf;
        w             = gen_word(m_pushed);
        xif.start     = st;
        xif.glb_valid = v;
        xif.bus_ready = r;
        xif.glb_ifmap = w.ifmap;
        xif.glb_fltr  = w.fltr;
        xif.glb_psum  = w.psum;
        rst           = rs;
        #1;
        exp_valid = m_busy && !m_flush && (m_q.size() > 0);
        exp_grdy  = m_busy && (m_q.size() < DEPTH) && (m_pushed < m_total);
        chk("busy",      xif.busy,      m_busy);
        chk("done",      xif.done,      m_done);
        chk("flush",     xif.bus_flush, m_flush);
        chk("glb_ready", xif.glb_ready, exp_grdy);
        chk("bus_valid", xif.bus_valid, exp_valid);
        if (xif.done === 1'b1) done_seen_at = cyc_no;
        if (m_flush) chk("y_tag", xif.bus_y_tag, m_beats / m_cols);
        if (exp_valid) begin
            chk("x_tag", xif.bus_x_tag, m_beats % m_cols);
            chk("ifmap", xif.bus_ifmap, m_q[0].ifmap);
            chk("fltr",  xif.bus_fltr,  m_q[0].fltr);
            chk("psum",  xif.bus_psum,  exp_psum(m_q[0]));
        end
        if (rs) begin
            model_reset();
        end else begin
            nb = m_busy;
            nd = 0;
            nf = 0;
            if (st && !m_busy && !m_done) begin
                m_cols   = int'(xif.cfg_cols);
                m_total  = int'(xif.cfg_rows) * m_cols;
                m_pushed = 0;
                m_beats  = 0;
                if (m_total == 0) nd = 1;
                else begin
                    nb = 1;
                    nf = 1;
                end
            end
            if (exp_valid && r) begin
                void'(m_q.pop_front());
                m_beats++;
                if (m_beats % m_cols == 0) begin
                    if (m_beats == m_total) begin
                        nb = 0;
                        nd = 1;
                    end else begin
                        nf = 1;
                    end
                end
            end
            if (v && exp_grdy) begin
                m_q.push_back(w);
                m_pushed++;
            end
            m_busy  = nb;
            m_done  = nd;
            m_flush = nf;
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // mode 0 best case, 1 mid-row stall, 2 random, 3 reset on 3rd beat,
    // 4 start held high (and cfg changed) while busy
    task automatic run_pass(input int rows, input int cols, input int mode,
                            output int len);
        int start_at, k;
        bit v, r, st, rs;
        xif.cfg_rows = rows[2:0];
        xif.cfg_cols = cols[2:0];
        start_at     = cyc_no;
        done_seen_at = -1;
        cyc(1'b1, (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1, 1'b1, 1'b0);
        k = 1;
        while ((m_busy || m_done) && (k < 400)) begin
            v  = 1;
            r  = 1;
            st = 0;
            rs = 0;
            case (mode)
                1: r = !(k >= 3 && k <= 5);
                2: begin
                    v  = ($urandom_range(0, 3) != 0);
                    r  = ($urandom_range(0, 2) != 0);
                    st = m_busy && ($urandom_range(0, 7) == 0);
                end
                3: rs = (m_beats == 2) && m_busy && !m_flush && (m_q.size() > 0);
                4: begin
                    st = m_busy;
                    xif.cfg_cols = 3'd1;
                end
                default: ;
            endcase
            cyc(st, v, r, rs);
            k++;
            if (rs) break;
        end
        chk("idle_after_pass", xif.busy, 0);
        len = (done_seen_at < 0) ? -1 : (done_seen_at - start_at);
    endtask

    initial begin
        int len;
        int rr, cc;
        rst           = 1'b1;
        xif.start     = 1'b0;
        xif.cfg_rows  = '0;
        xif.cfg_cols  = '0;
        xif.glb_valid = 1'b0;
        xif.glb_ifmap = '0;
        xif.glb_fltr  = '0;
        xif.glb_psum  = '0;
        xif.bus_ready = 1'b0;
        seed          = 16'h0000;
        psum_dead     = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // start cycle is cycle 1 of the pass, so done lands rows*(cols+1)+1 later
        run_pass(2, 3, 0, len);
        chk("bestcase_len", len, 2 * (3 + 1) + 1);

        seed = 16'h0100;
        run_pass(2, 3, 1, len);
        chk("stall_len", len, 2 * (3 + 1) + 1 + 3);

        run_pass(0, 3, 0, len);
        chk("rows0_len", len, 1);
        run_pass(3, 0, 0, len);
        chk("cols0_len", len, 1);

        seed = 16'h0200;
        run_pass(3, 2, 4, len);
        chk("start_busy_len", len, 3 * (2 + 1) + 1);

        seed = 16'h0300;
        run_pass(4, 4, 3, len);
        xif.start = 1'b0;
        check_reset_outs();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        seed = 16'h0400;
        run_pass(4, 4, 0, len);
        chk("after_rst_len", len, 4 * (4 + 1) + 1);

        psum_dead = 0;
        for (int i = 0; i < 40; i++) begin
            seed = 16'($urandom);
            rr   = $urandom_range(0, 4);
            cc   = $urandom_range(0, 4);
            run_pass(rr, cc, 2, len);
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end

        psum_dead = 1;
        seed      = 16'h0500;
        run_pass(4, 4, 2, len);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
